// File: rtl/omem_drain.sv
// Drains rows of the output memory into a DW-bit valid/ready element stream,
// optionally writing each row back to zero once all of its elements have been sent.
module omem_drain #(
    parameter int DW = 16,
    parameter int LN = 4,
    parameter int AW = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic [AW:0]      ROWS,
    input  logic [2:0]       LANES,
    input  logic             CLR,
    output logic             EN_O,
    output logic             RW_O,
    output logic [AW-1:0]    ADDR_O,
    output logic [LN*DW-1:0] WDATA_O,
    input  logic [LN*DW-1:0] RDATA_O,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [DW-1:0]    OUT_DATA,
    output logic             OUT_LAST,
    output logic             BUSY,
    output logic             DONE
);
    localparam int LW = (LN > 1) ? $clog2(LN) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_EM, S_WR, S_FIN} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [AW-1:0]         r_row;
    logic [AW-1:0]         r_rows_m1;
    logic [LW-1:0]         r_lane;
    logic [LW-1:0]         r_lanes_m1;
    logic                  r_clr;
    logic [LN-1:0][DW-1:0] r_word;

    logic                  w_last_row;
    logic                  w_last_lane;
    logic                  w_xfer;
    logic [LW-1:0]         w_lanes_m1;

    // Row and lane limits are held as "count minus one" so the compares stay AW/LW bits wide.
    assign w_last_row  = (r_row == r_rows_m1);
    assign w_last_lane = (r_lane == r_lanes_m1);
    assign w_xfer      = (r_state == S_EM) && OUT_READY;

    always_comb begin
        if (LANES == 3'd0 || int'(LANES) > LN) begin
            w_lanes_m1 = LW'(LN - 1);
        end else begin
            w_lanes_m1 = LW'(LANES - 3'd1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next = (ROWS == '0) ? S_FIN : S_RD;
                end
            end
            S_RD: w_next = S_WT;
            S_WT: w_next = S_EM;
            S_EM: begin
                if (w_xfer && w_last_lane) begin
                    if (r_clr) begin
                        w_next = S_WR;
                    end else if (w_last_row) begin
                        w_next = S_FIN;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_WR:    w_next = w_last_row ? S_FIN : S_RD;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: all state here updates with <= so every register sees pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_row      <= '0;
            r_rows_m1  <= '0;
            r_lane     <= '0;
            r_lanes_m1 <= '0;
            r_clr      <= 1'b0;
            r_word     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START && ROWS != '0) begin
                        r_rows_m1  <= AW'(ROWS - 1'b1);
                        r_lanes_m1 <= w_lanes_m1;
                        r_clr      <= CLR;
                        r_row      <= '0;
                    end
                end
                S_WT: begin
                    r_word <= RDATA_O;
                    r_lane <= '0;
                end
                S_EM: begin
                    if (w_xfer) begin
                        if (!w_last_lane) begin
                            r_lane <= r_lane + 1'b1;
                        end else if (!r_clr && !w_last_row) begin
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (!w_last_row) begin
                        r_row <= r_row + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode only registered state, row, lane and word, never OUT_READY or RDATA_O.
    always_comb begin
        EN_O      = (r_state == S_RD) || (r_state == S_WR);
        RW_O      = (r_state == S_WR);
        ADDR_O    = EN_O ? r_row : '0;
        WDATA_O   = '0;
        OUT_VALID = (r_state == S_EM);
        OUT_DATA  = OUT_VALID ? r_word[r_lane] : '0;
        OUT_LAST  = OUT_VALID && w_last_row && w_last_lane;
        BUSY      = (r_state != S_IDLE);
        DONE      = (r_state == S_FIN);
    end

endmodule

// File: tb/tb_omem_drain.sv
// Directed bench for omem_drain: a behavioural OMEM, a table of drain configurations
// checked beat by beat, and hand-written reset / START-while-busy sequences.
module tb_omem_drain;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        START;
    logic [4:0]  ROWS;
    logic [2:0]  LANES;
    logic        CLR;
    logic        EN_O;
    logic        RW_O;
    logic [3:0]  ADDR_O;
    logic [63:0] WDATA_O;
    logic [63:0] RDATA_O;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] OUT_DATA;
    logic        OUT_LAST;
    logic        BUSY;
    logic        DONE;

    always #5 CLK = ~CLK;

    omem_drain dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .START     (START),
        .ROWS      (ROWS),
        .LANES     (LANES),
        .CLR       (CLR),
        .EN_O      (EN_O),
        .RW_O      (RW_O),
        .ADDR_O    (ADDR_O),
        .WDATA_O   (WDATA_O),
        .RDATA_O   (RDATA_O),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_LAST  (OUT_LAST),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    // Behavioural OMEM: one-cycle read latency, write on EN_O && RW_O.
    logic [63:0] mem [16];
    logic [63:0] img_init [16];
    logic [63:0] exp_img [16];
    logic [63:0] rdata = '0;
    logic        init_req = 1'b0;

    assign RDATA_O = rdata;

    always @(posedge CLK) begin
        if (init_req) begin
            for (int i = 0; i < 16; i++) mem[i] <= img_init[i];
        end else if (EN_O) begin
            if (RW_O) mem[ADDR_O] <= WDATA_O;
            else      rdata <= mem[ADDR_O];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int rows;
        int lanes_in;
        int clr;
        int rmode;       // 0: READY always 1; 1: READY 1,0,0,1 over EM cycles
        int poke;        // pulse START with other settings while busy
        int reinit;      // reload OMEM with the initial image first
        int exp_lanes;   // effective lanes after normalisation
        int exp_cycles;  // cycles from the START edge to the DONE cycle
    } vec_t;

    task automatic load_mem();
        init_req = 1'b1;
        @(negedge CLK);
        init_req = 1'b0;
        for (int i = 0; i < 16; i++) exp_img[i] = img_init[i];
    endtask

    task automatic run_vec(input vec_t v);
        int          beats, em_k, reads, writes, dones, done_cyc, exp_beats, row, lane, bad_rows;
        bit          stalled, prev_lastlane, rdy;
        logic [63:0] w;
        beats = 0; em_k = 0; reads = 0; writes = 0; dones = 0; done_cyc = 0;
        stalled = 0; prev_lastlane = 0;
        exp_beats = v.rows * v.exp_lanes;
        if (v.reinit != 0) load_mem();
        START = 1'b1;
        ROWS  = 5'(v.rows);
        LANES = 3'(v.lanes_in);
        CLR   = v.clr[0];
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge CLK);
            START = (v.poke != 0 && cyc == 4);
            if (START) begin
                ROWS  = 5'd5;
                LANES = 3'd1;
                CLR   = ~v.clr[0];
            end
            if (done_cyc != 0) begin
                check("idle_after_done", {BUSY, DONE, OUT_VALID, EN_O}, 4'b0);
                break;
            end
            rdy = (v.rmode == 0) || (em_k % 4 == 0) || (em_k % 4 == 3);
            OUT_READY = rdy;
            if (stalled) check("stall_valid_held", OUT_VALID, 1'b1);
            stalled = 0;
            if (EN_O && !RW_O) begin
                reads++;
                check("rd_addr", ADDR_O, beats / v.exp_lanes);
            end
            if (EN_O && RW_O) begin
                writes++;
                check("wr_addr", ADDR_O, (beats - 1) / v.exp_lanes);
                check("wr_data", WDATA_O, 64'h0);
                check("wr_after_last_beat", prev_lastlane, 1'b1);
            end
            prev_lastlane = 0;
            if (OUT_VALID) begin
                em_k++;
                if (beats < exp_beats) begin
                    row  = beats / v.exp_lanes;
                    lane = beats % v.exp_lanes;
                    w    = exp_img[row];
                    check("data", OUT_DATA, w[lane*16 +: 16]);
                    check("last", OUT_LAST, beats == exp_beats - 1);
                    if (rdy) begin
                        beats++;
                        prev_lastlane = (lane == v.exp_lanes - 1);
                    end else begin
                        stalled = 1;
                    end
                end else begin
                    check("extra_beat", OUT_VALID, 1'b0);
                end
            end
            if (DONE) begin
                dones++;
                done_cyc = cyc;
            end
        end
        check("beats", beats, exp_beats);
        check("reads", reads, v.rows);
        check("writes", writes, (v.clr != 0) ? v.rows : 0);
        check("done_pulses", dones, 1);
        check("done_cycle", done_cyc, v.exp_cycles);
        if (v.clr != 0) begin
            for (int i = 0; i < v.rows; i++) exp_img[i] = '0;
        end
        bad_rows = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== exp_img[i]) bad_rows++;
        check("omem_contents", bad_rows, 0);
    endtask

    vec_t vecs [8];
    vec_t v_after_rst;
    int   cnt;

    initial begin
        img_init[0] = 64'h0004_0003_0002_0001;
        img_init[1] = 64'hFFFF_8000_7FFF_0005;
        for (int i = 2; i < 16; i++) begin
            img_init[i] = {16'(16'hA003 + i*16), 16'(16'hA002 + i*16),
                           16'(16'hA001 + i*16), 16'(16'hA000 + i*16)};
        end
        //              rows lanes clr rmode poke reinit eff cycles
        vecs[0] = '{2,  4, 0, 0, 0, 1, 4, 13};  // basic two-row drain
        vecs[1] = '{2,  4, 0, 1, 0, 0, 4, 21};  // same data, READY 1,0,0,1
        vecs[2] = '{16, 2, 1, 0, 0, 1, 2, 81};  // full depth with clear
        vecs[3] = '{16, 4, 0, 0, 0, 0, 4, 97};  // re-read: all rows now zero
        vecs[4] = '{0,  4, 0, 0, 0, 1, 4, 1};   // empty drain
        vecs[5] = '{1,  0, 0, 0, 0, 1, 4, 7};   // LANES=0 acts as 4
        vecs[6] = '{1,  7, 0, 0, 0, 1, 4, 7};   // LANES=7 acts as 4
        vecs[7] = '{3,  1, 1, 1, 1, 1, 1, 15};  // single lane, stalls, START while busy
        v_after_rst = '{1, 4, 0, 0, 0, 1, 4, 7};

        RSTN = 1'b0; START = 1'b0; ROWS = '0; LANES = '0; CLR = 1'b0; OUT_READY = 1'b1;
        repeat (2) @(negedge CLK);
        check("reset_outputs", {EN_O, RW_O, ADDR_O, OUT_VALID, OUT_DATA, OUT_LAST, BUSY, DONE}, '0);
        RSTN = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of row 1's elements, then a fresh one-row drain.
        load_mem();
        START = 1'b1; ROWS = 5'd2; LANES = 3'd4; CLR = 1'b1; OUT_READY = 1'b1;
        cnt = 0;
        for (int c = 0; c < 50 && cnt < 5; c++) begin
            @(negedge CLK);
            START = 1'b0;
            if (OUT_VALID) cnt++;
        end
        check("pre_reset_beats", cnt, 5);
        RSTN = 1'b0;
        @(negedge CLK);
        check("midrun_reset_outputs",
              {EN_O, RW_O, ADDR_O, OUT_VALID, OUT_DATA, OUT_LAST, BUSY, DONE}, '0);
        RSTN = 1'b1;
        @(negedge CLK);
        check("no_access_after_reset", {EN_O, BUSY, OUT_VALID}, 3'b0);
        run_vec(v_after_rst);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
